// File: rtl/rf_wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package rf_wb_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    localparam logic [AW-1:0] REG_ZERO = '0;

    typedef enum logic {
        PIPE_PRI  = 1'b0,
        MDU_FORCE = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic            valid;
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/rf_wb_starve_ctr.sv
// Counts consecutive cycles the MDU is denied and flags the last denied cycle
// before a forced grant is due.
module rf_wb_starve_ctr
    import rf_wb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mdu_valid,
    input  logic mdu_ready,
    output logic at_limit
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0] wait_cnt_d;

    // Any cycle without a denied MDU request breaks the streak.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!mdu_valid || mdu_ready) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != CNT_W'(STARVE_LIMIT)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign at_limit = (wait_cnt_q == CNT_W'(STARVE_LIMIT - 1));

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the single regfile write port between the WB stage and the MDU.
// Define RF_WB_STARVE_GUARD_EN to bound MDU starvation; otherwise pipe priority is strict.
module rf_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter int XLEN = rf_wb_pkg::XLEN,
    parameter int AW   = rf_wb_pkg::AW
`ifdef RF_WB_STARVE_GUARD_EN
    ,
    parameter int STARVE_LIMIT = 4
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pipe_valid,
    input  logic [AW-1:0]   pipe_addr,
    input  logic [XLEN-1:0] pipe_data,
    output logic            pipe_ready,
    input  logic            mdu_valid,
    input  logic [AW-1:0]   mdu_addr,
    input  logic [XLEN-1:0] mdu_data,
    output logic            mdu_ready,
    output logic            rf_we,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata
);

    logic            pipe_acc;
    logic            mdu_acc;
    logic            rf_we_q,    rf_we_d;
    logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

`ifdef RF_WB_STARVE_GUARD_EN
    arb_state_e state_q, state_d;
    logic       at_limit;

    rf_wb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .mdu_valid (mdu_valid),
        .mdu_ready (mdu_ready),
        .at_limit  (at_limit)
    );
`endif

    always_comb begin
        pipe_ready = 1'b0;
        mdu_ready  = 1'b0;
`ifdef RF_WB_STARVE_GUARD_EN
        state_d    = state_q;
        case (state_q)
            PIPE_PRI: begin
                pipe_ready = rst_n;
                mdu_ready  = rst_n & ~pipe_valid;
            end
            MDU_FORCE: begin
                mdu_ready = rst_n;
            end
            default: ;
        endcase
`else
        pipe_ready = rst_n;
        mdu_ready  = rst_n & ~pipe_valid;
`endif

        pipe_acc = pipe_valid & pipe_ready;
        mdu_acc  = mdu_valid & mdu_ready;

`ifdef RF_WB_STARVE_GUARD_EN
        case (state_q)
            PIPE_PRI: begin
                if (mdu_valid && !mdu_ready && at_limit) begin
                    state_d = MDU_FORCE;
                end
            end
            MDU_FORCE: begin
                // A dropped request while forced is a protocol slip; just recover.
                if (mdu_acc || !mdu_valid) begin
                    state_d = PIPE_PRI;
                end
            end
            default: state_d = PIPE_PRI;
        endcase
`endif

        // x0 writes still complete the handshake but never reach the regfile.
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (pipe_acc) begin
            rf_we_d    = (pipe_addr != AW'(REG_ZERO));
            rf_waddr_d = pipe_addr;
            rf_wdata_d = pipe_data;
        end else if (mdu_acc) begin
            rf_we_d    = (mdu_addr != AW'(REG_ZERO));
            rf_waddr_d = mdu_addr;
            rf_wdata_d = mdu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
`ifdef RF_WB_STARVE_GUARD_EN
            state_q    <= PIPE_PRI;
`endif
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
`ifdef RF_WB_STARVE_GUARD_EN
            state_q    <= state_d;
`endif
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter; covers both RF_WB_STARVE_GUARD_EN builds.
module tb_rf_wb_arbiter;
    import rf_wb_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            pipe_valid = 1'b0;
    logic [AW-1:0]   pipe_addr = '0;
    logic [XLEN-1:0] pipe_data = '0;
    logic            pipe_ready;
    logic            mdu_valid = 1'b0;
    logic [AW-1:0]   mdu_addr = '0;
    logic [XLEN-1:0] mdu_data = '0;
    logic            mdu_ready;
    logic            rf_we;
    logic [AW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;

    int checks = 0;
    int errors = 0;

    wr_req_t         sb[$];
    logic [AW-1:0]   hold_addr = '0;
    logic [XLEN-1:0] hold_data = '0;

    always #5 clk = ~clk;

    rf_wb_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pipe_valid (pipe_valid),
        .pipe_addr  (pipe_addr),
        .pipe_data  (pipe_data),
        .pipe_ready (pipe_ready),
        .mdu_valid  (mdu_valid),
        .mdu_addr   (mdu_addr),
        .mdu_data   (mdu_data),
        .mdu_ready  (mdu_ready),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata)
    );

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One cycle: drive, check readies, and queue the write expected one cycle later.
    task automatic applyStimulus(
        input logic            rst,
        input logic            pv,
        input logic [AW-1:0]   pa,
        input logic [XLEN-1:0] pd,
        input logic            mv,
        input logic [AW-1:0]   ma,
        input logic [XLEN-1:0] md,
        input logic            exp_pr,
        input logic            exp_mr
    );
        wr_req_t e;
        @(posedge clk);
        #1;
        rst_n      = rst;
        pipe_valid = pv;
        pipe_addr  = pa;
        pipe_data  = pd;
        mdu_valid  = mv;
        mdu_addr   = ma;
        mdu_data   = md;
        #1;
        checkOutput("pipe_ready", 64'(pipe_ready), 64'(exp_pr));
        checkOutput("mdu_ready", 64'(mdu_ready), 64'(exp_mr));
        if (!rst) begin
            hold_addr = '0;
            hold_data = '0;
            e = '0;
        end else if (pv && exp_pr) begin
            hold_addr = pa;
            hold_data = pd;
            e = '{valid: (pa != 0), addr: pa, data: pd};
        end else if (mv && exp_mr) begin
            hold_addr = ma;
            hold_data = md;
            e = '{valid: (ma != 0), addr: ma, data: md};
        end else begin
            e = '{valid: 1'b0, addr: hold_addr, data: hold_data};
        end
        sb.push_back(e);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b1);
    endtask

    initial begin
        wr_req_t e;
        forever begin
            @(posedge clk);
            #3;
            if (sb.size() >= 2) begin
                e = sb.pop_front();
                checkOutput("rf_we", 64'(rf_we), 64'(e.valid));
                checkOutput("rf_waddr", 64'(rf_waddr), 64'(e.addr));
                checkOutput("rf_wdata", 64'(rf_wdata), 64'(e.data));
            end
        end
    end

    initial begin
        $display("[TB] reset with both requesters valid");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 5'd1, 32'h1111_1111, 1'b1, 5'd2, 32'h2222_2222, 1'b0, 1'b0);
        end
        idleCycle();

        $display("[TB] single pipe write");
        applyStimulus(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, '0, 1'b1, 1'b0);
        idleCycle();

        $display("[TB] x0 write suppression");
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b1, 5'd0, 32'h0000_1234, 1'b1, 1'b1);
        idleCycle();

        $display("[TB] same-rd contention");
        applyStimulus(1'b1, 1'b1, 5'd3, 32'hAAAA_0001, 1'b1, 5'd3, 32'hBBBB_0002, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b1, 5'd3, 32'hBBBB_0002, 1'b1, 1'b1);
        idleCycle();

`ifdef RF_WB_STARVE_GUARD_EN
        $display("[TB] starvation guard forces an mdu grant");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 5'(10 + i), 32'h1000 + i, 1'b1, 5'd7, 32'h7777_0007, 1'b1, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 5'd14, 32'h1004, 1'b1, 5'd7, 32'h7777_0007, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 5'd14, 32'h1004, 1'b0, '0, '0, 1'b1, 1'b0);
        idleCycle();

        $display("[TB] reset while forced");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 5'(20 + i), 32'h2000 + i, 1'b1, 5'd9, 32'h9999_0009, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 5'd24, 32'h2004, 1'b1, 5'd9, 32'h9999_0009, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 5'd24, 32'h2004, 1'b1, 5'd9, 32'h9999_0009, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b1, 5'd9, 32'h9999_0009, 1'b1, 1'b1);
        idleCycle();
`else
        $display("[TB] strict pipe priority starves the mdu");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b1, 5'(10 + (i % 16)), 32'h1000 + i, 1'b1, 5'd7, 32'h7777_0007, 1'b1, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b1, 5'd7, 32'h7777_0007, 1'b1, 1'b1);
        idleCycle();
`endif

        idleCycle();
        @(posedge clk);
        #4;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
